// File: rtl/mux_n_reg.sv
// N-channel, WIDTH-bit registered selector. The channel is chosen either from a
// software-loaded select register or by a round-robin scan over valid channels.
//
// Valid/ready: a word moves across a channel (in_valid[k]/in_ready[k]) or out of
// the block (out_valid/out_ready) on a rising clk edge where both are high;
// valid never waits on ready, and in_ready[k] is high only for the chosen channel
// while the output register is empty or being drained in the same cycle.
module mux_n_reg #(
   parameter  int WIDTH = 64,
   parameter  int N     = 4,
   localparam int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic               sel_load,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SEL_W-1:0]   cur_sel
);

   logic [SEL_W-1:0] sel_reg;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] rr_pick;
   logic [SEL_W-1:0] rr_next;
   logic [SEL_W-1:0] chosen;
   logic [SEL_W:0]   idx;
   logic             can_load;
   logic             xfer;
   logic             sel_ok;

   // Scan from the highest offset down so the valid channel closest to rr_ptr wins.
   always_comb begin
      rr_pick = rr_ptr;
      idx     = '0;
      for (int i = N-1; i >= 0; i--) begin
         idx = {1'b0, rr_ptr} + (SEL_W+1)'(i);
         if (idx >= (SEL_W+1)'(N)) idx = idx - (SEL_W+1)'(N);
         if (in_valid[idx[SEL_W-1:0]]) rr_pick = idx[SEL_W-1:0];
      end
   end

   assign chosen   = mode ? rr_pick : sel_reg;
   assign cur_sel  = chosen;
   assign can_load = reset_n && (!out_valid || out_ready);
   assign xfer     = can_load && in_valid[chosen];
   assign sel_ok   = ({1'b0, sel} < (SEL_W+1)'(N));
   assign rr_next  = (chosen == SEL_W'(N-1)) ? '0 : chosen + 1'b1;

   always_comb begin
      in_ready = '0;
      if (can_load) in_ready[chosen] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         sel_reg   <= '0;
         rr_ptr    <= '0;
      end else begin
         if (xfer) begin
            out_data  <= in_data[chosen*WIDTH +: WIDTH];
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         // An in-range load overrides the round-robin advance in the same cycle.
         if (sel_load && sel_ok) begin
            sel_reg <= sel;
            rr_ptr  <= sel;
         end else if (mode && xfer) begin
            rr_ptr <= rr_next;
         end
      end
   end

endmodule

// File: tb/tb_mux_n_reg.sv
// Bench for mux_n_reg: a 4-channel and a 3-channel instance share one stimulus
// stream and are both compared against a spec-level model every cycle.
module tb_mux_n_reg;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [255:0]  din = '0;
   logic [3:0]    vin = '0;
   logic          mode = 1'b0;
   logic [1:0]    sel = '0;
   logic          sel_load = 1'b0;
   logic          out_ready = 1'b0;

   logic [63:0]   o_data[2];
   logic          o_valid[2];
   logic [3:0]    o_rdy[2];
   logic [1:0]    o_sel[2];
   logic [2:0]    rdy3;

   int            passed = 0;
   int            total = 0;

   // model state, index 0 = 4-channel instance, index 1 = 3-channel instance
   int            nch[2] = '{4, 3};
   int            m_sel[2];
   int            m_ptr[2];
   logic          m_valid[2];
   logic [63:0]   m_data[2];
   logic [63:0]   exp_q[$];

   int            ck_c;
   logic          ck_cl;
   logic [3:0]    ck_rdy;
   logic          ck_xf;
   logic [3:0]    ck_v;

   always #5 clk = ~clk;

   mux_n_reg #(.WIDTH(64), .N(4)) u4 (
      .clk(clk), .reset_n(reset_n), .in_data(din), .in_valid(vin),
      .in_ready(o_rdy[0]), .mode(mode), .sel(sel), .sel_load(sel_load),
      .out_data(o_data[0]), .out_valid(o_valid[0]), .out_ready(out_ready),
      .cur_sel(o_sel[0])
   );

   mux_n_reg #(.WIDTH(64), .N(3)) u3 (
      .clk(clk), .reset_n(reset_n), .in_data(din[191:0]), .in_valid(vin[2:0]),
      .in_ready(rdy3), .mode(mode), .sel(sel), .sel_load(sel_load),
      .out_data(o_data[1]), .out_valid(o_valid[1]), .out_ready(out_ready),
      .cur_sel(o_sel[1])
   );

   assign o_rdy[1] = {1'b0, rdy3};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
   endtask

   // First valid channel at or after the pointer, modulo n; pointer if none.
   function automatic int pick(int n, logic m, int s, int p, logic [3:0] v);
      if (!m) return s;
      for (int i = 0; i < n; i++)
         if (v[(p + i) % n]) return (p + i) % n;
      return p;
   endfunction

   function automatic logic [3:0] vin_of(int d);
      return (d == 0) ? vin : {1'b0, vin[2:0]};
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_sel[d] = 0; m_ptr[d] = 0; m_valid[d] = 1'b0; m_data[d] = '0;
      end
      exp_q.delete();
   endtask

   initial model_reset();
   always @(negedge reset_n) model_reset();

   // compare process: every outputs of both instances, each falling edge
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         ck_v   = vin_of(d);
         ck_c   = pick(nch[d], mode, m_sel[d], m_ptr[d], ck_v);
         ck_cl  = reset_n && (!m_valid[d] || out_ready);
         ck_rdy = ck_cl ? (4'b0001 << ck_c) : 4'b0000;
         chk($sformatf("cur_sel[%0d]", d), 64'(o_sel[d]), 64'(ck_c));
         chk($sformatf("in_ready[%0d]", d), 64'(o_rdy[d]), 64'(ck_rdy));
         chk($sformatf("out_valid[%0d]", d), 64'(o_valid[d]), 64'(m_valid[d]));
         chk($sformatf("out_data[%0d]", d), o_data[d], m_data[d]);
      end
      if (o_valid[0] && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL sb_pop: got out_valid=1 with data %h, want no pending word", o_data[0]);
         end else begin
            chk("sb_data", o_data[0], exp_q.pop_front());
         end
      end
   end

   // model update on the active edge; inputs change only 1 time unit later
   always @(posedge clk) begin
      if (reset_n) begin
         for (int d = 0; d < 2; d++) begin
            ck_v  = vin_of(d);
            ck_c  = pick(nch[d], mode, m_sel[d], m_ptr[d], ck_v);
            ck_xf = (!m_valid[d] || out_ready) && ck_v[ck_c];
            if (ck_xf) begin
               m_data[d]  = din[ck_c*64 +: 64];
               m_valid[d] = 1'b1;
               if (d == 0) exp_q.push_back(din[ck_c*64 +: 64]);
            end else if (out_ready) begin
               m_valid[d] = 1'b0;
            end
            if (sel_load && int'(sel) < nch[d]) begin
               m_sel[d] = int'(sel);
               m_ptr[d] = int'(sel);
            end else if (mode && ck_xf) begin
               m_ptr[d] = (ck_c + 1) % nch[d];
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_words(input logic [63:0] base);
      for (int k = 0; k < 4; k++) din[k*64 +: 64] = base + 64'(k);
   endtask

   initial begin
      // reset
      #3;
      chk("rst_out_valid", 64'(o_valid[0]), 64'd0);
      chk("rst_out_data", o_data[0], 64'd0);
      chk("rst_in_ready", 64'(o_rdy[0]), 64'd0);
      #10 reset_n = 1'b1;
      tick();

      // fixed select
      mode = 1'b0; sel = 2'd2; sel_load = 1'b1; vin = 4'hF; out_ready = 1'b1;
      set_words(64'h1000);
      din[2*64 +: 64] = 64'hDEAD_BEEF;
      tick();
      sel_load = 1'b0;
      #2;
      chk("fix_cur_sel", 64'(o_sel[0]), 64'd2);
      chk("fix_in_ready", 64'(o_rdy[0]), 64'b0100);
      chk("fix_old_word", o_data[0], 64'h1000);
      tick();
      #2;
      chk("fix_data", o_data[0], 64'hDEAD_BEEF);
      chk("fix_valid", 64'(o_valid[0]), 64'd1);

      // backpressure, then pop and load on one edge
      out_ready = 1'b0;
      tick();
      set_words(64'h5000);
      din[2*64 +: 64] = 64'hCAFE_F00D;
      #2;
      chk("bp_hold_data", o_data[0], 64'hDEAD_BEEF);
      chk("bp_in_ready", 64'(o_rdy[0]), 64'd0);
      tick();
      vin = 4'b0100;
      out_ready = 1'b1;
      #2;
      chk("bp_release_ready", 64'(o_rdy[0]), 64'b0100);
      tick();
      #2;
      chk("bp_pop_load_valid", 64'(o_valid[0]), 64'd1);
      chk("bp_pop_load_data", o_data[0], 64'hCAFE_F00D);

      // round-robin, all valid; the 3-channel instance wraps 0,1,2,0
      mode = 1'b1; sel = 2'd0; sel_load = 1'b1; vin = 4'h0;
      tick();
      sel_load = 1'b0; vin = 4'hF;
      set_words(64'hA0);
      for (int i = 0; i < 8; i++) begin
         #2;
         chk($sformatf("rr4_seq%0d", i), 64'(o_sel[0]), 64'(i % 4));
         chk($sformatf("rr3_seq%0d", i), 64'(o_sel[1]), 64'(i % 3));
         tick();
      end
      vin = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk($sformatf("rr13_seq%0d", i), 64'(o_sel[0]), (i % 2 == 0) ? 64'd1 : 64'd3);
         tick();
      end

      // out-of-range select is ignored by the 3-channel instance only
      mode = 1'b0; sel = 2'd3; sel_load = 1'b1; vin = 4'h0;
      tick();
      sel_load = 1'b0;
      #2;
      chk("sel3_ignored", 64'(o_sel[1]), 64'd0);
      chk("sel3_loaded", 64'(o_sel[0]), 64'd3);

      // load and transfer on the same edge
      tick();
      mode = 1'b1; sel = 2'd1; sel_load = 1'b1;
      tick();
      vin = 4'hF; sel = 2'd3; sel_load = 1'b1;
      #2;
      chk("sim_old_sel", 64'(o_sel[0]), 64'd1);
      tick();
      sel_load = 1'b0;
      #2;
      chk("sim_data", o_data[0], 64'hA1);
      chk("sim_new_sel", 64'(o_sel[0]), 64'd3);
      chk("sim_adv3", 64'(o_sel[1]), 64'd2);

      // async reset mid-stream
      out_ready = 1'b0;
      tick();
      #2;
      chk("ar_pre_valid", 64'(o_valid[0]), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("ar_valid", 64'(o_valid[0]), 64'd0);
      chk("ar_data", o_data[0], 64'd0);
      chk("ar_in_ready", 64'(o_rdy[0]), 64'd0);
      tick();
      #2 reset_n = 1'b1;
      mode = 1'b1; vin = 4'h0;
      #1;
      chk("ar_rr_ptr", 64'(o_sel[0]), 64'd0);
      mode = 1'b0;
      #1;
      chk("ar_sel_reg", 64'(o_sel[0]), 64'd0);
      tick();

      // randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         mode      = ($urandom_range(0, 3) != 0);
         sel_load  = ($urandom_range(0, 9) == 0);
         sel       = 2'($urandom_range(0, 3));
         vin       = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 4; k++) din[k*64 +: 64] = {$urandom, $urandom};
         if ($urandom_range(0, 299) == 0) begin
            #2 reset_n = 1'b0;
            #4 reset_n = 1'b1;
         end
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
Parametrised N-input, WIDTH-bit selector that replaces fixed 2:1/4:1 bit-level mux trees on wider datapaths. It has a registered output stage and a valid/ready handshake on every input channel and on the output. It supports two modes: a software-loaded fixed select, and a round-robin arbiter over valid channels. It sits between multiple producers (e.g. forwarding or writeback sources) and one registered consumer in the pipeline.

Parameters:
WIDTH, 64, data bits per channel (>=1)
N, 4, number of input channels (>=2; non-power-of-2 allowed)
SEL_W, $clog2(N), select/pointer width (derived, not overridden)

Ports:
clk        input   1          rising-edge clock
reset_n    input   1          asynchronous, active-low reset
in_data    input   N*WIDTH    channel k occupies bits [k*WIDTH +: WIDTH]
in_valid   input   N          channel k has data
in_ready   output  N          channel k transfer accepted this cycle
mode       input   1          0 = fixed select, 1 = round-robin
sel        input   SEL_W      new select/pointer value
sel_load   input   1          load sel on this clock edge
out_data   output  WIDTH      registered selected word
out_valid  output  1          out_data holds an untaken word
out_ready  input   1          consumer accepts out_data
cur_sel    output  SEL_W      channel chosen this cycle (combinational)

Behaviour:
- Clock, reset: single clock domain. Reset is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, sel_reg=0, rr_ptr=0. in_ready=0 while reset_n=0.
- Reset asserted mid-transfer: the held word is discarded. There is no output until a new transfer after reset deasserts.
- Chosen channel (combinational):
  - mode=0: chosen = sel_reg.
  - mode=1: chosen = first k with in_valid[k]=1, scanning rr_ptr, rr_ptr+1, … modulo N.
  - mode=1, no channel valid: chosen = rr_ptr.
- cur_sel = chosen.
- can_load = !out_valid || out_ready.
- in_ready[k] = can_load && (k == chosen). All other bits of in_ready are 0.
- Transfer: occurs when in_valid[chosen] && in_ready[chosen]. On that clock edge:
  - out_data <= in_data[chosen].
  - out_valid <= 1.
- Output handshake:
  - out_valid && out_ready && no transfer: out_valid <= 0 on the next edge.
  - Simultaneous pop and transfer: new word is loaded, out_valid stays 1, giving 1 word/cycle throughput.
  - out_valid && !out_ready: out_data and out_valid hold.
- Latency: a word accepted on edge T is visible on out_data from T until taken, i.e. 1 cycle.
- Round-robin advance: applies only in mode=1 on a transfer. rr_ptr <= (chosen==N-1) ? 0 : chosen+1. Wrap uses an explicit compare, never a power-of-2 mask.
- sel_load:
  - If sel < N: sel_reg <= sel and rr_ptr <= sel on that edge.
  - If sel >= N: ignored; both registers unchanged.
  - sel_load takes priority over the round-robin advance in the same cycle.
  - A transfer in the same cycle uses the old chosen value.
- Mode switch: takes effect combinationally the same cycle. sel_reg and rr_ptr are unchanged by a switch.
- No-transfer cases:
  - mode=0 and in_valid[sel_reg]=0: no transfer, even if other channels are valid.
  - mode=1 and all in_valid=0: no transfer and no pointer change.
- X-safety: out_data never captures an unselected channel. No latches. All state is in one always_ff with async reset.

Test Plan:
- Reset/fixed mode: WIDTH=64, N=4, mode=0, sel_load with sel=2, in_data[2]=64'hDEAD_BEEF, all valid, out_ready=1.
  -> out_data=DEAD_BEEF one edge later; in_ready=4'b0100; cur_sel=2.
- Backpressure: out_ready=0 with out_valid=1, inputs changing.
  -> out_data held; in_ready=0.
  - Raise out_ready with in_valid[2]=1.
  -> Pop and load happen on the same edge; out_valid stays 1.
- Round-robin fairness: mode=1, all four valid, out_ready=1 for 8 cycles.
  -> cur_sel sequence 0,1,2,3,0,1,2,3.
  - Repeat with only channels 1 and 3 valid.
  -> cur_sel sequence 1,3,1,3.
- Non-power-of-2 wrap: N=3, mode=1, all valid.
  -> cur_sel sequence 0,1,2,0; rr_ptr never reaches 3.
  - sel_load with sel=3.
  -> Ignored; sel_reg unchanged.
- Simultaneous load/transfer: mode=1, rr_ptr=1, transfer on channel 1 with sel_load sel=3 on the same edge.
  -> out_data = in_data[1]; next cur_sel=3 (not 2).
- Async reset mid-stream: drop reset_n between clock edges while out_valid=1.
  -> out_valid=0 and out_data=0 immediately; in_ready=0.
  - After release.
  -> rr_ptr=0, sel_reg=0.
